// File: rtl/gol_pkg.sv
// Shared types and helpers for the game-of-life board I/O blocks.
package gol_pkg;

  // Output stretcher phases: waiting, driving the pulse, enforced low gap.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } stretch_state_t;

  // Width of a down-counter that must hold values 0 .. max(a,b)-1.
  // Never returns less than 1, so single-cycle phases still get a real register.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m <= 1) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_stretch_out_cycle_timer.sv
// Loadable down-counter shared by the HOLD and GAP phases of the stretcher.
// A load wins over counting; the counter parks at zero until the next load.
module cycle_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] r_count;

  // Load a new phase length, otherwise count down and stop at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/pulse_stretch_out.sv
// Turns one-cycle command pulses into fixed-width level pulses for LEDs/buzzers.
// Each accepted request gives HOLD_CYCLES high followed by GAP_CYCLES low.
// Requests arriving while busy are queued as a saturating count and replayed.
//
// Request semantics: pulse_in has no ready/back-pressure. Every cycle it is high
// is one request. A request is either started (IDLE, or last GAP cycle with an
// empty queue), queued (pending < MAX_PENDING), swapped with a dequeue (last GAP
// cycle with a non-empty queue), or dropped with a one-cycle overflow flag.
module pulse_stretch_out
  import gol_pkg::*;
#(
  parameter  int HOLD_CYCLES = 4,
  parameter  int GAP_CYCLES  = 2,
  parameter  int MAX_PENDING = 3,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse_in,
  output logic             out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output stretch_state_t   dbg_state
);

  localparam int               TMR_W     = timer_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = CNT_W'(MAX_PENDING);

  stretch_state_t   r_state;
  logic             r_out;
  logic             r_busy;
  logic [CNT_W-1:0] r_pending;
  logic             r_overflow;

  logic             w_tmr_zero;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_value;
  logic             w_last_gap;
  logic             w_pend_nz;
  logic             w_pend_full;
  logic             w_restart;

  assign w_last_gap  = (r_state == S_GAP) && w_tmr_zero;
  assign w_pend_nz   = (r_pending != '0);
  assign w_pend_full = (r_pending == PEND_MAX);
  assign w_restart   = w_last_gap && (w_pend_nz || pulse_in);

  // Timer reload: start of HOLD from IDLE or GAP, start of GAP at end of HOLD.
  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_value = HOLD_LOAD;
    case (r_state)
      S_IDLE: begin
        if (pulse_in) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (w_tmr_zero) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (w_restart) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = HOLD_LOAD;
        end
      end
      default: begin
        w_tmr_load  = 1'b0;
        w_tmr_value = HOLD_LOAD;
      end
    endcase
  end

  cycle_timer #(
    .W(TMR_W)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (w_tmr_load),
    .value (w_tmr_value),
    .zero  (w_tmr_zero)
  );

  // Phase FSM with registered out/busy, plus the pending queue and overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_out      <= 1'b0;
      r_busy     <= 1'b0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (pulse_in) begin
            r_state <= S_HOLD;
            r_out   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_tmr_zero) begin
            r_state <= S_GAP;
            r_out   <= 1'b0;
          end
        end
        S_GAP: begin
          if (w_restart) begin
            r_state <= S_HOLD;
            r_out   <= 1'b1;
          end else if (w_tmr_zero) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase

      // The queue only moves while busy; IDLE is only entered with it empty.
      if (r_state != S_IDLE) begin
        if (w_last_gap) begin
          // A queued request is consumed here; a new one on the same cycle
          // either replaces it in the queue or starts directly when empty.
          if (w_pend_nz && !pulse_in) begin
            r_pending <= r_pending - CNT_W'(1);
          end
        end else if (pulse_in) begin
          if (w_pend_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_pending <= r_pending + CNT_W'(1);
          end
        end
      end
    end
  end

  assign out       = r_out;
  assign busy      = r_busy;
  assign pending   = r_pending;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule
